tlb_pipe: RTL and testbench
===========================

# tlb_pipe

Parametrised successor TLB for the myCPU MIPS pipeline: fully associative, TLBNUM entries of dual-page (even/odd) mappings. Two search ports (fetch and memory stages) have registered, one-cycle results. Adds a per-entry present bit, a hardware Random index counter for TLBWR, and a multi-cycle invalidate engine. It sits between the CP0 TLB instruction logic and the IF/MEM address translation paths.

## Interface
- TLBNUM, 16, entry count; power of two, 4..64; IDX = $clog2(TLBNUM).
- WIRED, 0, lowest index the Random counter may produce; 0..TLBNUM-2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s0_valid  in  1  search request on port 0, sampled at posedge.
- s0_vpn2 / s0_odd_page / s0_asid  in  19/1/8  search key.
- s0_resp_valid  out  1  result registers valid; high the cycle after an accepted request.
- s0_found / s0_multi  out  1/1  hit; more than one entry hit.
- s0_index  out  IDX  index of the hit entry.
- s0_pfn / s0_c / s0_d / s0_v  out  20/3/1/1  selected page payload.
- s1_*  identical set for port 1.
- we  in  1  write enable; ignored while inv_busy.
- w_index  in  IDX  target entry.
- w_vpn2 / w_asid / w_g  in  19/8/1  tag fields.
- w_pfn0 / w_c0 / w_d0 / w_v0  in  20/3/1/1  even page.
- w_pfn1 / w_c1 / w_d1 / w_v1  in  20/3/1/1  odd page.
- r_index  in  IDX  read index.
- r_vpn2 .. r_v1  out  as w_*  combinational read of entry r_index; r_e out 1 present bit.
- rand_index  out  IDX  current Random value for TLBWR.
- inv_req  in  1  start invalidate; accepted only when !inv_busy.
- inv_mode  in  2  0 all, 1 all non-global with asid==inv_asid, 2 asid-or-global match and vpn2==inv_vpn2, 3 reserved (treated as 0).
- inv_asid / inv_vpn2  in  8/19  invalidate key.
- inv_busy / inv_done  out  1/1  walk in progress; one-cycle completion pulse.

## Operation
- Entry match: present && vpn2 equal && (asid equal || g). Entries without the present bit never hit.
- Search: on posedge with sN_valid, compute match over all entries and register the results. On multiple hits, the lowest index wins, and sN_multi=1 when TLB_MULTIHIT_EN is defined. Payload is selected by the registered odd_page.
- When sN_valid=0, the result registers hold their last values and sN_resp_valid=0.
- Write: when we && !inv_busy, all fields of w_index are written and its present bit is set at posedge.
- Random: rand_index decrements by 1 every cycle. From WIRED it wraps to TLBNUM-1. On a cycle with an accepted write, it reloads to TLBNUM-1.
- Invalidate FSM: IDLE -> WALK on inv_req, latching mode, asid and vpn2, with cnt=0.
  - WALK checks entry cnt each cycle and clears its present bit if it matches the mode. cnt increments.
  - At cnt==TLBNUM-1, WALK -> DONE. DONE lasts one cycle with inv_done=1, then -> IDLE.
  - inv_busy=1 in WALK and DONE.
- Searches stay legal during the walk and see the present bits as of that cycle.

## Timing
- Search latency is 1 cycle; a new search is accepted every cycle per port.
- Write vs. search in the same cycle: the search uses the pre-write contents. The new entry is visible to searches issued the next cycle.
- Read port is combinational; it reflects a write from the following cycle onward.
- An invalidate takes TLBNUM+1 cycles from acceptance to the inv_done pulse.
- inv_req while busy: ignored.
- we during WALK/DONE: dropped, with no state change.
- Reset values:
  - All present bits 0; sN_resp_valid, found, multi, index, pfn, c, d, v all 0.
  - rand_index=TLBNUM-1.
  - FSM IDLE; inv_busy=0, inv_done=0.
- Reset mid-walk aborts the walk and applies the reset values.
- Other array fields are not reset. r_* are undefined for non-present entries, except r_e=0.

## Configuration
- TLB_MULTIHIT_EN defined: sN_multi flags more than one hit, as an aid for CP0 machine-check detection.
- TLB_MULTIHIT_EN undefined: sN_multi is tied to 0 and the population-count logic is removed. Lowest-index priority still applies.

## Test plan
- Reset, write entry 3 (vpn2=0x12345, asid=5, g=0, pfn1=0xABCDE, v1=1), search port 0 with odd_page=1, asid=5 -> next cycle resp_valid=1, found=1, index=3, pfn=0xABCDE, v=1. Same search with asid=6 -> found=0.
- Write and search the same key in the same cycle -> found=0. Repeat the search next cycle -> found=1.
- Entries 2 and 9 with equal vpn2 and g=1 -> index=2. With TLB_MULTIHIT_EN, multi=1; without it, multi=0.
- TLBNUM=16, WIRED=4: reset then free-run -> rand_index 15,14,...,4,15. An accepted write at value 9 -> 15 next cycle.
- inv_mode=1, inv_asid=5 with entries {asid5 g0, asid5 g1, asid7 g0} -> inv_done at cycle 17. Only the asid5 g0 entry loses its present bit, and a we asserted during the walk is dropped.
- Assert reset during WALK -> busy=0, no entries present, and a subsequent inv_req is accepted.

Source files
------------

// File: rtl/tlb_pipe.sv
// Fully associative dual-page TLB with two registered search ports, present bits,
// Random index counter and a sequential invalidate walker. Optional: TLB_MULTIHIT_EN.
module tlb_pipe #(
    parameter int TLBNUM = 16,
    parameter int WIRED  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s0_valid,
    input  logic [18:0]               s0_vpn2,
    input  logic                      s0_odd_page,
    input  logic [7:0]                s0_asid,
    output logic                      s0_resp_valid,
    output logic                      s0_found,
    output logic                      s0_multi,
    output logic [$clog2(TLBNUM)-1:0] s0_index,
    output logic [19:0]               s0_pfn,
    output logic [2:0]                s0_c,
    output logic                      s0_d,
    output logic                      s0_v,
    input  logic                      s1_valid,
    input  logic [18:0]               s1_vpn2,
    input  logic                      s1_odd_page,
    input  logic [7:0]                s1_asid,
    output logic                      s1_resp_valid,
    output logic                      s1_found,
    output logic                      s1_multi,
    output logic [$clog2(TLBNUM)-1:0] s1_index,
    output logic [19:0]               s1_pfn,
    output logic [2:0]                s1_c,
    output logic                      s1_d,
    output logic                      s1_v,
    input  logic                      we,
    input  logic [$clog2(TLBNUM)-1:0] w_index,
    input  logic [18:0]               w_vpn2,
    input  logic [7:0]                w_asid,
    input  logic                      w_g,
    input  logic [19:0]               w_pfn0,
    input  logic [2:0]                w_c0,
    input  logic                      w_d0,
    input  logic                      w_v0,
    input  logic [19:0]               w_pfn1,
    input  logic [2:0]                w_c1,
    input  logic                      w_d1,
    input  logic                      w_v1,
    input  logic [$clog2(TLBNUM)-1:0] r_index,
    output logic [18:0]               r_vpn2,
    output logic [7:0]                r_asid,
    output logic                      r_g,
    output logic [19:0]               r_pfn0,
    output logic [2:0]                r_c0,
    output logic                      r_d0,
    output logic                      r_v0,
    output logic [19:0]               r_pfn1,
    output logic [2:0]                r_c1,
    output logic                      r_d1,
    output logic                      r_v1,
    output logic                      r_e,
    output logic [$clog2(TLBNUM)-1:0] rand_index,
    input  logic                      inv_req,
    input  logic [1:0]                inv_mode,
    input  logic [7:0]                inv_asid,
    input  logic [18:0]               inv_vpn2,
    output logic                      inv_busy,
    output logic                      inv_done
);
    localparam int IDX = $clog2(TLBNUM);
    localparam logic [IDX-1:0] LAST    = IDX'(TLBNUM - 1);
    localparam logic [IDX-1:0] WIRED_I = IDX'(WIRED);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [18:0] ent_vpn2_q [TLBNUM];
    logic [7:0]  ent_asid_q [TLBNUM];
    logic        ent_g_q    [TLBNUM];
    logic [19:0] ent_pfn0_q [TLBNUM];
    logic [2:0]  ent_c0_q   [TLBNUM];
    logic        ent_d0_q   [TLBNUM];
    logic        ent_v0_q   [TLBNUM];
    logic [19:0] ent_pfn1_q [TLBNUM];
    logic [2:0]  ent_c1_q   [TLBNUM];
    logic        ent_d1_q   [TLBNUM];
    logic        ent_v1_q   [TLBNUM];
    logic [TLBNUM-1:0] ent_e_q;

    logic [1:0]     state_q, state_d;
    logic [IDX-1:0] cnt_q, cnt_d;
    logic [1:0]     mode_q;
    logic [7:0]     key_asid_q;
    logic [18:0]    key_vpn2_q;
    logic [IDX-1:0] rand_q, rand_d;
    logic           wr_ok, inv_hit;

    assign inv_busy = (state_q != S_IDLE);
    assign inv_done = (state_q == S_DONE);
    assign wr_ok    = we && !inv_busy;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ent_vpn2_q[w_index] <= w_vpn2;
            ent_asid_q[w_index] <= w_asid;
            ent_g_q[w_index]    <= w_g;
            ent_pfn0_q[w_index] <= w_pfn0;
            ent_c0_q[w_index]   <= w_c0;
            ent_d0_q[w_index]   <= w_d0;
            ent_v0_q[w_index]   <= w_v0;
            ent_pfn1_q[w_index] <= w_pfn1;
            ent_c1_q[w_index]   <= w_c1;
            ent_d1_q[w_index]   <= w_d1;
            ent_v1_q[w_index]   <= w_v1;
        end
    end

    assign r_vpn2 = ent_vpn2_q[r_index];
    assign r_asid = ent_asid_q[r_index];
    assign r_g    = ent_g_q[r_index];
    assign r_pfn0 = ent_pfn0_q[r_index];
    assign r_c0   = ent_c0_q[r_index];
    assign r_d0   = ent_d0_q[r_index];
    assign r_v0   = ent_v0_q[r_index];
    assign r_pfn1 = ent_pfn1_q[r_index];
    assign r_c1   = ent_c1_q[r_index];
    assign r_d1   = ent_d1_q[r_index];
    assign r_v1   = ent_v1_q[r_index];
    assign r_e    = ent_e_q[r_index];

    // Mode 3 is reserved and behaves like mode 0 (flush everything).
    always_comb begin
        case (mode_q)
            2'd1:    inv_hit = !ent_g_q[cnt_q] && (ent_asid_q[cnt_q] == key_asid_q);
            2'd2:    inv_hit = (ent_g_q[cnt_q] || (ent_asid_q[cnt_q] == key_asid_q))
                               && (ent_vpn2_q[cnt_q] == key_vpn2_q);
            default: inv_hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (inv_req) begin
                state_d = S_WALK;
                cnt_d   = '0;
            end
            S_WALK: begin
                cnt_d = cnt_q + IDX'(1);
                if (cnt_q == LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (wr_ok || rand_q == WIRED_I) rand_d = LAST;
        else                            rand_d = rand_q - IDX'(1);
    end

    assign rand_index = rand_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mode_q     <= 2'd0;
            key_asid_q <= '0;
            key_vpn2_q <= '0;
            rand_q     <= LAST;
            ent_e_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rand_q  <= rand_d;
            if (state_q == S_IDLE && inv_req) begin
                mode_q     <= inv_mode;
                key_asid_q <= inv_asid;
                key_vpn2_q <= inv_vpn2;
            end
            // Writes are blocked while busy, so the set and clear never collide.
            if (wr_ok) ent_e_q[w_index] <= 1'b1;
            if (state_q == S_WALK && inv_hit) ent_e_q[cnt_q] <= 1'b0;
        end
    end

    logic [1:0]       sk_valid, sk_odd;
    logic [1:0][18:0] sk_vpn2;
    logic [1:0][7:0]  sk_asid;
    assign sk_valid = {s1_valid, s0_valid};
    assign sk_odd   = {s1_odd_page, s0_odd_page};
    assign sk_vpn2  = {s1_vpn2, s0_vpn2};
    assign sk_asid  = {s1_asid, s0_asid};

    for (genvar p = 0; p < 2; p++) begin : g_srch
        logic [TLBNUM-1:0] hit;
        logic [IDX-1:0]    hidx;
        logic              mhit;
        logic              rv_q, found_q, multi_q;
        logic [IDX-1:0]    idx_q;
        logic [19:0]       pfn_q;
        logic [2:0]        c_q;
        logic              d_q, v_q;

        always_comb begin
            hit = '0;
            for (int i = 0; i < TLBNUM; i++)
                hit[i] = ent_e_q[i] && (ent_vpn2_q[i] == sk_vpn2[p])
                         && (ent_g_q[i] || (ent_asid_q[i] == sk_asid[p]));
        end

        always_comb begin
            hidx = '0;
            for (int i = TLBNUM - 1; i >= 0; i--)
                if (hit[i]) hidx = IDX'(i);
        end

`ifdef TLB_MULTIHIT_EN
        assign mhit = |(hit & (hit - TLBNUM'(1)));
`else
        assign mhit = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                rv_q    <= 1'b0;
                found_q <= 1'b0;
                multi_q <= 1'b0;
                idx_q   <= '0;
                pfn_q   <= '0;
                c_q     <= '0;
                d_q     <= 1'b0;
                v_q     <= 1'b0;
            end else begin
                rv_q <= sk_valid[p];
                if (sk_valid[p]) begin
                    found_q <= |hit;
                    multi_q <= mhit;
                    idx_q   <= hidx;
                    // A miss returns a zero payload rather than a stale entry.
                    if (!(|hit)) begin
                        pfn_q <= '0;
                        c_q   <= '0;
                        d_q   <= 1'b0;
                        v_q   <= 1'b0;
                    end else if (sk_odd[p]) begin
                        pfn_q <= ent_pfn1_q[hidx];
                        c_q   <= ent_c1_q[hidx];
                        d_q   <= ent_d1_q[hidx];
                        v_q   <= ent_v1_q[hidx];
                    end else begin
                        pfn_q <= ent_pfn0_q[hidx];
                        c_q   <= ent_c0_q[hidx];
                        d_q   <= ent_d0_q[hidx];
                        v_q   <= ent_v0_q[hidx];
                    end
                end
            end
        end
    end

    assign s0_resp_valid = g_srch[0].rv_q;
    assign s0_found      = g_srch[0].found_q;
    assign s0_multi      = g_srch[0].multi_q;
    assign s0_index      = g_srch[0].idx_q;
    assign s0_pfn        = g_srch[0].pfn_q;
    assign s0_c          = g_srch[0].c_q;
    assign s0_d          = g_srch[0].d_q;
    assign s0_v          = g_srch[0].v_q;
    assign s1_resp_valid = g_srch[1].rv_q;
    assign s1_found      = g_srch[1].found_q;
    assign s1_multi      = g_srch[1].multi_q;
    assign s1_index      = g_srch[1].idx_q;
    assign s1_pfn        = g_srch[1].pfn_q;
    assign s1_c          = g_srch[1].c_q;
    assign s1_d          = g_srch[1].d_q;
    assign s1_v          = g_srch[1].v_q;
endmodule

// File: tb/tb_tlb_pipe.sv
// Directed bench for tlb_pipe (TLBNUM=16, WIRED=4); multi-hit expectation follows TLB_MULTIHIT_EN.
module tb_tlb_pipe;
    logic clk = 1'b0, reset = 1'b1;
    logic s0_valid = 0, s0_odd_page = 0, s1_valid = 0, s1_odd_page = 0;
    logic [18:0] s0_vpn2 = 0, s1_vpn2 = 0, w_vpn2 = 0, inv_vpn2 = 0, r_vpn2;
    logic [7:0] s0_asid = 0, s1_asid = 0, w_asid = 0, inv_asid = 0, r_asid;
    logic s0_resp_valid, s0_found, s0_multi, s0_d, s0_v;
    logic s1_resp_valid, s1_found, s1_multi, s1_d, s1_v;
    logic [3:0] s0_index, s1_index, rand_index, w_index = 0, r_index = 0;
    logic [19:0] s0_pfn, s1_pfn, w_pfn0 = 0, w_pfn1 = 0, r_pfn0, r_pfn1;
    logic [2:0] s0_c, s1_c, w_c0 = 0, w_c1 = 0, r_c0, r_c1;
    logic we = 0, w_g = 0, w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
    logic r_g, r_d0, r_v0, r_d1, r_v1, r_e;
    logic inv_req = 0, inv_busy, inv_done;
    logic [1:0] inv_mode = 0;
    int vecs = 0, errs = 0;

    tlb_pipe #(.TLBNUM(16), .WIRED(4)) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_resp_valid(s0_resp_valid), .s0_found(s0_found), .s0_multi(s0_multi), .s0_index(s0_index),
        .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_valid(s1_valid), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_resp_valid(s1_resp_valid), .s1_found(s1_found), .s1_multi(s1_multi), .s1_index(s1_index),
        .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .r_e(r_e),
        .rand_index(rand_index),
        .inv_req(inv_req), .inv_mode(inv_mode), .inv_asid(inv_asid), .inv_vpn2(inv_vpn2),
        .inv_busy(inv_busy), .inv_done(inv_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic g, input logic [19:0] p0, input logic v0,
                         input logic [19:0] p1, input logic v1);
        w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = p0; w_c0 = 3'd2; w_d0 = 1'b0; w_v0 = v0;
        w_pfn1 = p1; w_c1 = 3'd3; w_d1 = 1'b1; w_v1 = v1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                            input logic g, input logic [19:0] p0, input logic v0,
                            input logic [19:0] p1, input logic v1);
        set_w(idx, vpn2, asid, g, p0, v0, p1, v1);
        we = 1'b1; step(); we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        vecs++; if (s0_resp_valid !== 1'b0) begin errs++; $display("FAIL rst_rv0 got %0h want 0", s0_resp_valid); end
        vecs++; if ({s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== '0) begin errs++; $display("FAIL rst_s0 got %0h want 0", {s0_found, s0_multi, s0_index, s0_pfn, s0_c, s0_d, s0_v}); end
        vecs++; if ({s1_resp_valid, s1_found, s1_index, s1_pfn} !== '0) begin errs++; $display("FAIL rst_s1 got %0h want 0", {s1_resp_valid, s1_found, s1_index, s1_pfn}); end
        vecs++; if (rand_index !== 4'd15) begin errs++; $display("FAIL rst_rand got %0d want 15", rand_index); end
        vecs++; if ({inv_busy, inv_done} !== 2'b00) begin errs++; $display("FAIL rst_inv got %b want 00", {inv_busy, inv_done}); end
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i); #1;
            vecs++; if (r_e !== 1'b0) begin errs++; $display("FAIL rst_e[%0d] got %0h want 0", i, r_e); end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int n;
        reset = 1'b1; step();
        vecs++; if (rand_index !== 4'd15) begin errs++; $display("FAIL rand_rst got %0d want 15", rand_index); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            vecs++;
            if (rand_index !== ((k == 12) ? 4'd15 : 4'(15 - k))) begin
                errs++; $display("FAIL rand_seq k=%0d got %0d want %0d", k, rand_index, (k == 12) ? 15 : 15 - k);
            end
        end
        n = 0;
        while (rand_index !== 4'd9 && n < 40) begin step(); n++; end
        vecs++; if (n >= 40) begin errs++; $display("FAIL rand_wait9 got timeout want 9"); end
        do_write(4'd0, 19'h1, 8'h1, 1'b0, 20'h1, 1'b1, 20'h1, 1'b1);
        vecs++; if (rand_index !== 4'd15) begin errs++; $display("FAIL rand_reload got %0d want 15", rand_index); end
        step();
        vecs++; if (rand_index !== 4'd14) begin errs++; $display("FAIL rand_after got %0d want 14", rand_index); end
    endtask

    task automatic test_search();
        do_reset();
        do_write(4'd3, 19'h12345, 8'd5, 1'b0, 20'h11111, 1'b0, 20'hABCDE, 1'b1);
        s0_valid = 1; s0_vpn2 = 19'h12345; s0_odd_page = 1; s0_asid = 8'd5;
        step(); s0_valid = 0;
        vecs++; if (s0_resp_valid !== 1'b1) begin errs++; $display("FAIL srch_rv got %0h want 1", s0_resp_valid); end
        vecs++; if ({s0_found, s0_multi, s0_index} !== {1'b1, 1'b0, 4'd3}) begin errs++; $display("FAIL srch_hit got %0h want %0h", {s0_found, s0_multi, s0_index}, {1'b1, 1'b0, 4'd3}); end
        vecs++; if ({s0_pfn, s0_c, s0_d, s0_v} !== {20'hABCDE, 3'd3, 1'b1, 1'b1}) begin errs++; $display("FAIL srch_odd got %0h want %0h", {s0_pfn, s0_c, s0_d, s0_v}, {20'hABCDE, 3'd3, 1'b1, 1'b1}); end
        // Both ports in one cycle: port 0 misses on asid, port 1 hits the even page.
        s0_valid = 1; s0_asid = 8'd6;
        s1_valid = 1; s1_vpn2 = 19'h12345; s1_odd_page = 0; s1_asid = 8'd5;
        step(); s0_valid = 0; s1_valid = 0;
        vecs++; if ({s0_resp_valid, s0_found} !== 2'b10) begin errs++; $display("FAIL srch_asid_miss got %b want 10", {s0_resp_valid, s0_found}); end
        vecs++; if ({s1_resp_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== {1'b1, 1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b0}) begin errs++; $display("FAIL srch_even got %0h want %0h", {s1_resp_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}, {1'b1, 1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b0}); end
        step();
        vecs++; if ({s1_resp_valid, s1_found, s1_pfn} !== {1'b0, 1'b1, 20'h11111}) begin errs++; $display("FAIL srch_hold got %0h want %0h", {s1_resp_valid, s1_found, s1_pfn}, {1'b0, 1'b1, 20'h11111}); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        r_index = 4'd5; #1;
        vecs++; if (r_e !== 1'b0) begin errs++; $display("FAIL rd_pre got %0h want 0", r_e); end
        set_w(4'd5, 19'h00777, 8'd9, 1'b0, 20'h22222, 1'b1, 20'h33333, 1'b0);
        we = 1; s0_valid = 1; s0_vpn2 = 19'h00777; s0_odd_page = 0; s0_asid = 8'd9;
        step(); we = 0;
        vecs++; if ({s0_resp_valid, s0_found} !== 2'b10) begin errs++; $display("FAIL same_cyc got %b want 10", {s0_resp_valid, s0_found}); end
        vecs++; if ({r_e, r_vpn2, r_asid, r_pfn0} !== {1'b1, 19'h00777, 8'd9, 20'h22222}) begin errs++; $display("FAIL rd_post got %0h want %0h", {r_e, r_vpn2, r_asid, r_pfn0}, {1'b1, 19'h00777, 8'd9, 20'h22222}); end
        step(); s0_valid = 0;
        vecs++; if ({s0_found, s0_index, s0_pfn, s0_v} !== {1'b1, 4'd5, 20'h22222, 1'b1}) begin errs++; $display("FAIL next_cyc got %0h want %0h", {s0_found, s0_index, s0_pfn, s0_v}, {1'b1, 4'd5, 20'h22222, 1'b1}); end
    endtask

    task automatic test_multihit();
        logic exp_multi;
`ifdef TLB_MULTIHIT_EN
        exp_multi = 1'b1;
`else
        exp_multi = 1'b0;
`endif
        do_reset();
        do_write(4'd9, 19'h0AAAA, 8'd1, 1'b1, 20'h99999, 1'b1, 20'h0, 1'b0);
        do_write(4'd2, 19'h0AAAA, 8'd2, 1'b1, 20'h22AAA, 1'b1, 20'h0, 1'b0);
        s0_valid = 1; s0_vpn2 = 19'h0AAAA; s0_odd_page = 0; s0_asid = 8'h33;
        step(); s0_valid = 0;
        vecs++; if ({s0_found, s0_index, s0_pfn} !== {1'b1, 4'd2, 20'h22AAA}) begin errs++; $display("FAIL multi_prio got %0h want %0h", {s0_found, s0_index, s0_pfn}, {1'b1, 4'd2, 20'h22AAA}); end
        vecs++; if (s0_multi !== exp_multi) begin errs++; $display("FAIL multi_flag got %0h want %0h", s0_multi, exp_multi); end
    endtask

    task automatic test_invalidate();
        int n;
        do_reset();
        do_write(4'd0, 19'h100, 8'd5, 1'b0, 20'h1, 1'b1, 20'h1, 1'b1);
        do_write(4'd1, 19'h101, 8'd5, 1'b1, 20'h2, 1'b1, 20'h2, 1'b1);
        do_write(4'd2, 19'h102, 8'd7, 1'b0, 20'h3, 1'b1, 20'h3, 1'b1);
        inv_req = 1; inv_mode = 2'd1; inv_asid = 8'd5;
        step(); inv_req = 0; n = 1;
        vecs++; if ({inv_busy, inv_done} !== 2'b10) begin errs++; $display("FAIL inv_start got %b want 10", {inv_busy, inv_done}); end
        // Both a write and a mode-0 restart during the walk must be ignored.
        set_w(4'd10, 19'h200, 8'd1, 1'b0, 20'h5, 1'b1, 20'h5, 1'b1);
        we = 1; inv_req = 1; inv_mode = 2'd0;
        step(); we = 0; inv_req = 0; n++;
        while (inv_done !== 1'b1 && n < 40) begin step(); n++; end
        vecs++; if (n !== 17) begin errs++; $display("FAIL inv_latency got %0d want 17", n); end
        vecs++; if (inv_busy !== 1'b1) begin errs++; $display("FAIL inv_done_busy got %0h want 1", inv_busy); end
        step();
        vecs++; if ({inv_busy, inv_done} !== 2'b00) begin errs++; $display("FAIL inv_idle got %b want 00", {inv_busy, inv_done}); end
        r_index = 4'd0; #1; vecs++; if (r_e !== 1'b0) begin errs++; $display("FAIL inv_e0 got %0h want 0", r_e); end
        r_index = 4'd1; #1; vecs++; if (r_e !== 1'b1) begin errs++; $display("FAIL inv_e1 got %0h want 1", r_e); end
        r_index = 4'd2; #1; vecs++; if (r_e !== 1'b1) begin errs++; $display("FAIL inv_e2 got %0h want 1", r_e); end
        r_index = 4'd10; #1; vecs++; if (r_e !== 1'b0) begin errs++; $display("FAIL inv_drop_we got %0h want 0", r_e); end
    endtask

    task automatic test_reset_walk();
        int n;
        do_write(4'd4, 19'h300, 8'd3, 1'b0, 20'h7, 1'b1, 20'h7, 1'b1);
        inv_req = 1; inv_mode = 2'd2; inv_asid = 8'd3; inv_vpn2 = 19'h7FFFF;
        step(); inv_req = 0;
        for (int k = 0; k < 4; k++) step();
        reset = 1; step();
        vecs++; if ({inv_busy, inv_done} !== 2'b00) begin errs++; $display("FAIL rstwalk_busy got %b want 00", {inv_busy, inv_done}); end
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i); #1;
            vecs++; if (r_e !== 1'b0) begin errs++; $display("FAIL rstwalk_e[%0d] got %0h want 0", i, r_e); end
        end
        reset = 0;
        inv_req = 1; inv_mode = 2'd0;
        step(); inv_req = 0;
        vecs++; if (inv_busy !== 1'b1) begin errs++; $display("FAIL rstwalk_reaccept got %0h want 1", inv_busy); end
        n = 0;
        while (inv_done !== 1'b1 && n < 40) begin step(); n++; end
        vecs++; if (n !== 16) begin errs++; $display("FAIL rstwalk_done got %0d want 16", n); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_search();
        test_same_cycle();
        test_multihit();
        test_invalidate();
        test_reset_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
